// File: rtl/iqdemap_multi.sv
// iqdemap_multi: hard-decision I/Q demapper (BPSK / QPSK / 16QAM) with
// LSB-first packing of decided bits into WORD_W-bit words.
// Optional feature: define IQDEMAP_FLUSH_EN to add flush_i, which emits a
// partially filled word (zero-padded above the fill pointer).
module iqdemap_multi #(
  parameter int IN_W   = 11,
  parameter int WORD_W = 128,
  parameter int TH16   = 256
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ce,
  input  logic [1:0]               mode,
  input  logic                     valid_i,
  input  logic signed [IN_W-1:0]   ar,
  input  logic signed [IN_W-1:0]   ai,
`ifdef IQDEMAP_FLUSH_EN
  input  logic                     flush_i,
`endif
  output logic                     valid_raw,
  output logic [3:0]               raw,
  output logic [2:0]               raw_n,
  output logic                     valid_o,
  output logic [WORD_W-1:0]        writer_data,
  output logic                     err_o
);

  localparam int              PTR_W  = $clog2(WORD_W + 1);
  localparam logic [IN_W:0]   TH_MAG = (IN_W + 1)'(TH16);

  // A word must hold a whole number of 16QAM nibbles so no symbol straddles words.
  if (WORD_W % 4 != 0) begin : g_word_w_check
    $error("iqdemap_multi: WORD_W must be a multiple of 4");
  end

  // Magnitude one bit wider than the input so the most negative code stays positive.
  function automatic logic [IN_W:0] mag(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] xe;
    xe = IN_W'(1) == 0 ? '0 : {x[IN_W-1], x};
    return xe[IN_W] ? (IN_W + 1)'(-xe) : xe;
  endfunction

  // Strictly positive test: zero decides as 0.
  function automatic logic is_pos(input logic signed [IN_W-1:0] x);
    return !x[IN_W-1] && (x != '0);
  endfunction

  function automatic logic [3:0] decide(input logic [1:0] md,
                                        input logic signed [IN_W-1:0] xr,
                                        input logic signed [IN_W-1:0] xi);
    logic [3:0] b;
    b = {mag(xi) < TH_MAG, mag(xr) < TH_MAG, is_pos(xi), is_pos(xr)};
    case (md)
      2'd0:    return {3'b000, b[0]};
      2'd1:    return {2'b00, b[1:0]};
      default: return b;
    endcase
  endfunction

  function automatic logic [2:0] nbits(input logic [1:0] md);
    case (md)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  logic [WORD_W-1:0] word_q, word_d, writer_q, writer_d, base_word;
  logic [PTR_W-1:0]  ptr_q, ptr_d, base_ptr, sum_ptr;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        raw_q, raw_d, sym_bits;
  logic [2:0]        raw_n_q, raw_n_d, sym_n;
  logic              valid_raw_q, valid_raw_d, valid_o_q, valid_o_d, err_q, err_d;

  // Symbol acceptance, mode-change discard, packing, word completion and flush.
  always_comb begin
    word_d      = word_q;
    writer_d    = writer_q;
    ptr_d       = ptr_q;
    mode_d      = mode_q;
    raw_d       = raw_q;
    raw_n_d     = raw_n_q;
    valid_raw_d = 1'b0;
    valid_o_d   = 1'b0;
    err_d       = 1'b0;
    base_word   = word_q;
    base_ptr    = ptr_q;
    sum_ptr     = '0;
    sym_bits    = '0;
    sym_n       = '0;
    if (ce) begin
      if (valid_i) begin
        if (mode == 2'd3) begin
          err_d = 1'b1;
        end else begin
          sym_bits = decide(mode, ar, ai);
          sym_n    = nbits(mode);
          if (mode != mode_q && ptr_q != '0) begin
            base_word = '0;
            base_ptr  = '0;
          end
          sum_ptr     = base_ptr + PTR_W'(sym_n);
          word_d      = base_word | (WORD_W'(sym_bits) << base_ptr);
          ptr_d       = sum_ptr;
          raw_d       = sym_bits;
          raw_n_d     = sym_n;
          valid_raw_d = 1'b1;
          mode_d      = mode;
          if (sum_ptr == PTR_W'(WORD_W)) begin
            writer_d  = word_d;
            valid_o_d = 1'b1;
            ptr_d     = '0;
            word_d    = '0;
          end
        end
      end
`ifdef IQDEMAP_FLUSH_EN
      // Bits above the pointer are already zero, so the partial word is the padded word.
      if (flush_i && ptr_d != '0) begin
        writer_d  = word_d;
        valid_o_d = 1'b1;
        ptr_d     = '0;
        word_d    = '0;
      end
`endif
    end
  end

  // State and output registers with synchronous reset to all zeros.
  always_ff @(posedge CLK) begin
    if (RST) begin
      word_q      <= '0;
      writer_q    <= '0;
      ptr_q       <= '0;
      mode_q      <= '0;
      raw_q       <= '0;
      raw_n_q     <= '0;
      valid_raw_q <= 1'b0;
      valid_o_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      word_q      <= word_d;
      writer_q    <= writer_d;
      ptr_q       <= ptr_d;
      mode_q      <= mode_d;
      raw_q       <= raw_d;
      raw_n_q     <= raw_n_d;
      valid_raw_q <= valid_raw_d;
      valid_o_q   <= valid_o_d;
      err_q       <= err_d;
    end
  end

  assign valid_raw   = valid_raw_q;
  assign raw         = raw_q;
  assign raw_n       = raw_n_q;
  assign valid_o     = valid_o_q;
  assign writer_data = writer_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_iqdemap_multi.sv
// Testbench for iqdemap_multi: directed sequences, a decision table and
// randomized traffic checked against a queue-based reference model.
module tb_iqdemap_multi;

  localparam int IN_W   = 11;
  localparam int WORD_W = 128;
  localparam int TH16   = 256;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b0;
  logic                   ce = 1'b0;
  logic                   valid_i = 1'b0;
  logic                   flush = 1'b0;
  logic [1:0]             mode = '0;
  logic signed [IN_W-1:0] ar = '0;
  logic signed [IN_W-1:0] ai = '0;
  logic                   valid_raw, valid_o, err_o;
  logic [3:0]             raw;
  logic [2:0]             raw_n;
  logic [WORD_W-1:0]      writer_data;

  iqdemap_multi #(.IN_W(IN_W), .WORD_W(WORD_W), .TH16(TH16)) dut (
    .CLK(CLK), .RST(RST), .ce(ce), .mode(mode), .valid_i(valid_i),
    .ar(ar), .ai(ai),
`ifdef IQDEMAP_FLUSH_EN
    .flush_i(flush),
`endif
    .valid_raw(valid_raw), .raw(raw), .raw_n(raw_n), .valid_o(valid_o),
    .writer_data(writer_data), .err_o(err_o)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending bits of the current word, oldest first.
  bit                q[$];
  int                m_mode = 0;
  logic              e_vraw = 0, e_vo = 0, e_err = 0;
  logic [3:0]        e_raw = '0;
  logic [2:0]        e_rawn = '0;
  logic [WORD_W-1:0] e_wd = '0;

  int n_vraw, n_vo, n_raw1, n_err;

  typedef struct {
    int         a;
    int         b;
    logic [3:0] r;
  } qam_vec_t;

  function automatic logic [WORD_W-1:0] pack_q();
    logic [WORD_W-1:0] w;
    w = '0;
    foreach (q[i]) w[i] = q[i];
    return w;
  endfunction

  task automatic chk(input string nm, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit c, input bit v, input int md, input int a, input int b, input bit fl);
    int n;
    bit bb[4];
    if (RST) begin
      e_vraw = 0; e_vo = 0; e_err = 0; e_raw = '0; e_rawn = '0; e_wd = '0;
      q.delete();
      m_mode = 0;
    end else begin
      e_vraw = 0; e_vo = 0; e_err = 0;
      if (c) begin
        if (v) begin
          if (md == 3) begin
            e_err = 1;
          end else begin
            n = (md == 0) ? 1 : (md == 1) ? 2 : 4;
            bb[0] = (a > 0);
            bb[1] = (b > 0);
            bb[2] = ((a < 0 ? -a : a) < TH16);
            bb[3] = ((b < 0 ? -b : b) < TH16);
            if (md != m_mode && q.size() != 0) q.delete();
            e_raw = '0;
            for (int i = 0; i < n; i++) begin
              e_raw[i] = bb[i];
              q.push_back(bb[i]);
            end
            e_rawn = n[2:0];
            e_vraw = 1;
            m_mode = md;
            if (q.size() == WORD_W) begin
              e_wd = pack_q();
              e_vo = 1;
              q.delete();
            end
          end
        end
`ifdef IQDEMAP_FLUSH_EN
        if (fl && q.size() != 0) begin
          e_wd = pack_q();
          e_vo = 1;
          q.delete();
        end
`endif
      end
    end
  endtask

  task automatic step(input bit c, input bit v, input int md, input int a, input int b, input bit fl);
    ce = c; valid_i = v; mode = md[1:0]; ar = a[IN_W-1:0]; ai = b[IN_W-1:0]; flush = fl;
    model_update(c, v, md, a, b, fl);
    @(posedge CLK);
    #1;
    chk("valid_raw", valid_raw, e_vraw);
    chk("raw", raw, e_raw);
    chk("raw_n", raw_n, e_rawn);
    chk("valid_o", valid_o, e_vo);
    chk("writer_data", writer_data, e_wd);
    chk("err_o", err_o, e_err);
    if (valid_raw) n_vraw++;
    if (valid_raw && raw[0]) n_raw1++;
    if (valid_o) n_vo++;
    if (err_o) n_err++;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    RST = 1'b0;
    n_vraw = 0; n_vo = 0; n_raw1 = 0; n_err = 0;
  endtask

  function automatic int rnd_s();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  initial begin
    qam_vec_t tab[3];
    int md_cur;
    tab[0] = '{a: 100,   b: -300, r: 4'b0101};
    tab[1] = '{a: -256,  b: 255,  r: 4'b1010};
    tab[2] = '{a: -1024, b: 0,    r: 4'b1000};

    // Reset state
    do_reset();
    chk("rst_writer_data", writer_data, '0);
    chk("rst_valid_o", valid_o, 1'b0);

    // BPSK word
    for (int i = 0; i < 128; i++)
      step(1, 1, 0, (i < 8) ? ((i % 2 == 0) ? 1 : -1) : -1, 0, 0);
    chk("bpsk_vraw_cnt", n_vraw, 128);
    chk("bpsk_raw1_cnt", n_raw1, 4);
    chk("bpsk_vo_cnt", n_vo, 1);
    chk("bpsk_word", writer_data, 128'h55);

    // QPSK word
    n_vo = 0;
    for (int i = 0; i < 64; i++) begin
      step(1, 1, 1, (i == 0) ? 5 : -5, -5, 0);
      if (i == 0) chk("qpsk_raw0", raw, 4'b0001);
      if (i == 1) chk("qpsk_raw1", raw, 4'b0000);
    end
    chk("qpsk_vo_cnt", n_vo, 1);
    chk("qpsk_word", writer_data, 128'h1);

    // 16QAM decision table, then fill the 32-nibble word
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2, tab[i].a, tab[i].b, 0);
      chk("qam_raw", raw, tab[i].r);
      chk("qam_raw_n", raw_n, 3'd4);
    end
    for (int i = 0; i < 29; i++) step(1, 1, 2, rnd_s(), rnd_s(), 0);
    chk("qam_vo_cnt", n_vo, 1);
    chk("qam_pack", writer_data[11:0], 12'h8A5);

    // Mode switch discards partial BPSK word; reserved mode flags error only
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, 0, rnd_s(), rnd_s(), 0);
    step(1, 1, 1, 7, 7, 0);
    chk("switch_no_vo", n_vo, 0);
    step(1, 1, 3, 7, 7, 0);
    chk("reserved_err", err_o, 1'b1);
    chk("reserved_no_vraw", valid_raw, 1'b0);
    for (int i = 0; i < 63; i++) step(1, 1, 1, rnd_s(), rnd_s(), 0);
    chk("switch_vo_cnt", n_vo, 1);
    chk("switch_err_cnt", n_err, 1);

    // ce gating mid-word
    do_reset();
    for (int i = 0; i < 60; i++) step(1, 1, 0, rnd_s(), 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, rnd_s(), 0, 0);
      chk("ce_off_vraw", valid_raw, 1'b0);
    end
    for (int i = 0; i < 68; i++) step(1, 1, 0, rnd_s(), 0, 0);
    chk("ce_vo_cnt", n_vo, 1);

    // Reset mid-word
    for (int i = 0; i < 50; i++) step(1, 1, 0, 3, 0, 0);
    do_reset();
    chk("midrst_writer", writer_data, '0);
    chk("midrst_raw", raw, '0);
    for (int i = 0; i < 128; i++) step(1, 1, 0, rnd_s(), 0, 0);
    chk("midrst_vo_cnt", n_vo, 1);

`ifdef IQDEMAP_FLUSH_EN
    // Flush a partial word, then a flush with nothing pending
    do_reset();
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, -1, 0, 1);
    chk("flush_vo", valid_o, 1'b1);
    chk("flush_word", writer_data, 128'h3);
    step(1, 0, 0, 0, 0, 1);
    chk("flush_empty_vo", valid_o, 1'b0);
`endif

    // Randomized traffic against the model
    do_reset();
    md_cur = 0;
    for (int i = 0; i < 3000; i++) begin
      int md;
      int a;
      int b;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 79) == 0) md_cur = int'($urandom_range(0, 2));
        md = ($urandom_range(0, 29) == 0) ? 3 : md_cur;
        a = rnd_s();
        b = rnd_s();
        if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 1) == 1) ? -1024 : TH16;
        if ($urandom_range(0, 15) == 0) b = ($urandom_range(0, 1) == 1) ? -TH16 : 0;
        step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, md, a, b,
             $urandom_range(0, 39) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
